ustream_acc: RTL

Unary-to-binary accumulation stage that sits directly downstream of the stochastic multiplier. It sequences one multiplication window: it pulses the multiplier's operand-load and sequence-clear controls, then counts the ones on the product bitstream for 2^WINDOWLOG cycles. It scales the count to BITWIDTH bits and presents the binary result on a valid/ready handshake to the next stage.

---
 rtl/ustream_acc.sv | 92 +++++++++
 1 files changed

// File: rtl/ustream_acc.sv
// Accumulates ones from a stochastic product bitstream over a 2^WINDOWLOG window,
// sequencing the multiplier's load/clear pulses and handing off a scaled result.
module ustream_acc #(
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned WINDOWLOG = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic                iBit,
  output logic                oLoadB,
  output logic                oClr,
  output logic                oBusy,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oResult
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WINDOWLOG:0]   ones;
  logic [WINDOWLOG:0]   ones_next;
  logic [WINDOWLOG-1:0] cyc;
  logic                 last_cyc;
  logic [BITWIDTH-1:0]  scaled;

  assign ones_next = ones + (WINDOWLOG+1)'(iBit);
  assign last_cyc  = (cyc == '1);

  // Only a full window (N = 2^WINDOWLOG) overflows the kept bits, so the MSB alone selects saturation.
  always_comb begin
    scaled = ones_next[WINDOWLOG-1 -: BITWIDTH];
    if (ones_next[WINDOWLOG])
      scaled = '1;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (iStart) state_next = LOAD;
      LOAD: state_next = RUN;
      RUN:  if (last_cyc) state_next = DONE;
      DONE: begin
        if (iReady)
          state_next = iStart ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      ones    <= '0;
      cyc     <= '0;
      oResult <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          ones <= '0;
          cyc  <= '0;
        end
        RUN: begin
          ones <= ones_next;
          cyc  <= cyc + 1'b1;
          if (last_cyc)
            oResult <= scaled;
        end
        default: ;
      endcase
    end
  end

  assign oLoadB = (state == LOAD);
  assign oClr   = (state == LOAD);
  assign oBusy  = (state == LOAD) || (state == RUN);
  assign oValid = (state == DONE);

endmodule
